// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - datapath/PC width and reset PC
//   - DCache-freeze and redirect FSM state encodings (2 bits each)
//   - performance counter width
package pipe_hazard_ctrl_pkg;

  localparam int           WORD_W     = 32;
  localparam logic [31:0]  PC_RST_DEF = 32'h1c00_0000;
  localparam int           PERF_W     = 32;

  typedef enum logic [1:0] {
    D_RUN  = 2'd0,
    D_WAIT = 2'd1
  } d_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1
  } r_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Wrapping event counter with asynchronous active-high reset.
// Ports:
//   clk, rst   clock / async reset (count -> 0)
//   i_en       add one at the next clock edge
//   o_count    current count, wraps modulo 2^W
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Arbitrates DCache-miss freeze (highest priority), EX branch redirects
// (immediate, or deferred while the ICache refills) and load-use bubbles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// D_RUN   | no DCache miss outstanding
// D_WAIT  | DCache miss outstanding; pipeline frozen until dcache_ready
// R_IDLE  | no redirect pending
// R_PEND  | redirect latched in r_pend_target, waiting for ICache idle
//
// Ports:
//   clk, rst                       clock / async active-high reset
//   i_icache_busy                  ICache refill, current fetch invalid
//   i_br_redirect, i_br_target     EX mispredict and correct PC
//   i_ld_use_hazard                ID depends on an EX load
//   i_mem_req, i_dcache_ready      MEM request and completion
//   o_pc_stall/redirect/target     PC register control
//   o_*_stall, o_*_flush           pipeline register control
//   o_perf_*                       cycle / dstall / redirect counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int               WORD   = WORD_W,
  parameter logic [WORD-1:0]  PC_RST = PC_RST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_icache_busy,
  input  logic            i_br_redirect,
  input  logic [WORD-1:0] i_br_target,
  input  logic            i_ld_use_hazard,
  input  logic            i_mem_req,
  input  logic            i_dcache_ready,
  output logic            o_pc_stall,
  output logic            o_pc_redirect,
  output logic [WORD-1:0] o_pc_redirect_target,
  output logic            o_if_id_stall,
  output logic            o_id_ex_stall,
  output logic            o_ex_mem_stall,
  output logic            o_if_id_flush,
  output logic            o_id_ex_flush,
  output logic            o_ex_mem_flush,
  output logic            o_mem_wb_flush,
  output logic [WORD-1:0] o_perf_cycles,
  output logic [WORD-1:0] o_perf_dstall,
  output logic [WORD-1:0] o_perf_redirects
);

  d_state_t        r_dstate;
  r_state_t        r_rstate;
  r_state_t        w_rstate_nxt;
  logic [WORD-1:0] r_pend_target;
  logic [WORD-1:0] w_pend_nxt;
  logic            w_freeze;

  // Freeze is combinational so the miss cycle itself is already held.
  always_comb begin
    w_freeze = 1'b0;
    if (!rst) begin
      case (r_dstate)
        D_RUN:   w_freeze = i_mem_req & ~i_dcache_ready;
        D_WAIT:  w_freeze = ~i_dcache_ready;
        default: w_freeze = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dstate <= D_RUN;
    end else begin
      case (r_dstate)
        D_RUN:   if (i_mem_req && !i_dcache_ready) r_dstate <= D_WAIT;
        D_WAIT:  if (i_dcache_ready) r_dstate <= D_RUN;
        default: r_dstate <= D_RUN;
      endcase
    end
  end

  always_comb begin
    o_pc_stall           = 1'b0;
    o_pc_redirect        = 1'b0;
    o_pc_redirect_target = r_pend_target;
    o_if_id_stall        = 1'b0;
    o_id_ex_stall        = 1'b0;
    o_ex_mem_stall       = 1'b0;
    o_if_id_flush        = 1'b0;
    o_id_ex_flush        = 1'b0;
    o_ex_mem_flush       = 1'b0;
    o_mem_wb_flush       = 1'b0;
    w_rstate_nxt         = r_rstate;
    w_pend_nxt           = r_pend_target;
    if (rst) begin
      w_rstate_nxt = R_IDLE;
    end else if (w_freeze) begin
      // WB gets bubbles so a held MEM stage never writes back twice.
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
      o_mem_wb_flush = 1'b1;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (i_br_redirect) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            if (i_icache_busy) begin
              o_pc_stall   = 1'b1;
              w_pend_nxt   = i_br_target;
              w_rstate_nxt = R_PEND;
            end else begin
              o_pc_redirect        = 1'b1;
              o_pc_redirect_target = i_br_target;
            end
          end else if (i_ld_use_hazard) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (i_icache_busy) begin
            o_pc_stall    = 1'b1;
            o_if_id_flush = 1'b1;
          end
        end
        R_PEND: begin
          // Whatever the ICache returns now is wrong-path and is discarded.
          o_if_id_flush = 1'b1;
          if (i_br_redirect) begin
            o_id_ex_flush = 1'b1;
            w_pend_nxt    = i_br_target;
          end
          if (i_icache_busy) begin
            o_pc_stall = 1'b1;
          end else begin
            o_pc_redirect        = 1'b1;
            o_pc_redirect_target = i_br_redirect ? i_br_target : r_pend_target;
            w_rstate_nxt         = R_IDLE;
          end
        end
        default: w_rstate_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate      <= R_IDLE;
      r_pend_target <= PC_RST;
    end else begin
      r_rstate      <= w_rstate_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  perf_counter #(.W(WORD)) u_perf_cycles (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (o_perf_cycles)
  );

  perf_counter #(.W(WORD)) u_perf_dstall (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_freeze),
    .o_count (o_perf_dstall)
  );

  perf_counter #(.W(WORD)) u_perf_redirects (
    .clk     (clk),
    .rst     (rst),
    .i_en    (o_pc_redirect),
    .o_count (o_perf_redirects)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LoongArch32 pipeline (IF, ID, EX, MEM, WB).
- Drives the stall and flush inputs of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Arbitrates three hazard sources: DCache miss freeze, EX branch redirect (including redirects that arrive while the ICache is busy), and load-use bubbles.
- Maintains 32-bit performance counters.

Parameters:
- WORD, 32, datapath/PC width
- PC_RST, 32'h1c000000, reset value of the latched redirect target

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- icache_busy  in  1  ICache refill in progress; current fetch not valid
- br_redirect  in  1  EX stage resolved a mispredict this cycle
- br_target  in  WORD  correct PC for br_redirect
- ld_use_hazard  in  1  ID source register matches an EX load destination
- mem_req  in  1  MEM stage holds a load/store
- dcache_ready  in  1  DCache completes the MEM request this cycle
- pc_stall  out  1  hold the PC
- pc_redirect  out  1  load pc_redirect_target into the PC
- pc_redirect_target  out  WORD  redirect PC
- if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble
- perf_cycles, perf_dstall, perf_redirects  out  WORD each  counters

Behaviour:
- Reset: async. Effects: dstate=D_RUN, rstate=R_IDLE, pend_target=PC_RST, all counters 0. All control outputs are forced to 0 while rst=1.
- D FSM (DCache freeze)
  - D_RUN -> D_WAIT when mem_req & ~dcache_ready.
  - D_WAIT -> D_RUN when dcache_ready.
  - freeze = (dstate==D_RUN & mem_req & ~dcache_ready) | (dstate==D_WAIT & ~dcache_ready). Combinational, so the freeze is active in the miss cycle itself.
  - In D_WAIT, mem_req is ignored: the request is held by the cache handshake.
- freeze=1 has top priority:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1; mem_wb_flush is 1 (WB sees bubbles, never a duplicate write).
  - All other flushes are 0; br_redirect and ld_use_hazard are ignored; R FSM state and pend_target are unchanged.
- Cycle with dcache_ready=1: freeze=0, mem_wb_flush=0, so MEM_WB captures the load data at the next edge.
- R FSM (redirect), evaluated only when freeze=0:
  - R_IDLE & br_redirect & ~icache_busy: pc_redirect=1, pc_redirect_target=br_target, if_id_flush=1, id_ex_flush=1. Stay in R_IDLE.
  - R_IDLE & br_redirect & icache_busy: pend_target<=br_target, pc_stall=1, if_id_flush=1, id_ex_flush=1, pc_redirect=0. Go to R_PEND.
  - R_PEND & icache_busy: pc_stall=1, if_id_flush=1.
  - R_PEND & ~icache_busy: pc_redirect=1, pc_redirect_target=pend_target, if_id_flush=1 (discards the wrong-path fetch that just returned). Go to R_IDLE.
  - R_PEND & br_redirect (newer branch): pend_target<=br_target, id_ex_flush=1. Remain in or leave R_PEND per icache_busy as above; when leaving, pc_redirect_target=br_target.
- Load-use, only when freeze=0, no redirect action this cycle, rstate=R_IDLE: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- ICache busy with no other action: pc_stall=1, if_id_flush=1.
- ex_mem_flush is reserved for exceptions and is constant 0 in this revision.
- pc_redirect_target = pend_target whenever pc_redirect=0.
- Counters, all wrapping modulo 2^WORD:
  - perf_cycles +1 every cycle after reset.
  - perf_dstall +1 each cycle freeze=1.
  - perf_redirects +1 each cycle pc_redirect=1.
- Reset mid-miss or mid-pending: both FSMs return to idle and the pending target is lost; the reset fetch restarts at PC_RST.

Decomposition:
- Shared header CPU_Parameter.vh provides WORD, PC_RST, the D_RUN/D_WAIT and R_IDLE/R_PEND encodings (2 bits each), and the PERF_W width.
- One sub-module, perf_counter (enable-driven, wrapping, async-reset counter), instantiated three times.

Test Plan:
- Reset: rst=1 with br_redirect=1 -> all control outputs 0, counters 0; after release, perf_cycles=1 one cycle later.
- DCache miss: mem_req=1, dcache_ready=0 for 3 cycles, then 1 -> 3 cycles of pc/if_id/id_ex/ex_mem stall=1 and mem_wb_flush=1, then a cycle with all 0; perf_dstall=3.
- Direct redirect: br_redirect=1, br_target=32'h1c000040, icache_busy=0 -> same cycle pc_redirect=1, target=32'h1c000040, if_id_flush=id_ex_flush=1; perf_redirects=1.
- Pending redirect: br_redirect with target 32'h1c000080 while icache_busy=1 for 4 cycles -> pc_redirect=0 and pc_stall=1 for 4 cycles; pc_redirect=1 with target 32'h1c000080 on the first cycle icache_busy=0.
- Priority: freeze, br_redirect and ld_use_hazard all high -> stalls only and mem_wb_flush=1, no pc_redirect; when the freeze drops with br_redirect still high -> redirect taken, no load-use bubble.
- Load-use: ld_use_hazard=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 for exactly that cycle.
